// File: rtl/ram_burst_reader.sv
// Burst reader: issues sequential RAM reads and streams the returned words
// through a 2-entry skid buffer to a valid/ready sink.
module ram_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state;
  logic [LW-1:0]         issue_left;
  logic [LW-1:0]         beats_left;
  logic                  rd_pend;
  logic                  sk_valid;
  logic [DATA_WIDTH-1:0] sk_data;
  logic                  pop;
  logic                  accept;
  logic [1:0]            occ;

  // Words held or in flight once this cycle's pop is accounted for.
  // Crediting the pop keeps one word per cycle flowing while never
  // committing more than two words of storage.
  assign pop    = m_valid && m_ready;
  assign occ    = 2'(m_valid) + 2'(sk_valid) + 2'(rd_pend) - 2'(pop);
  assign ram_re = (state == READ) && (issue_left != '0) && (occ < 2'd2);
  assign accept = (state == IDLE) && start && (length != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ram_addr   <= '0;
      issue_left <= '0;
      beats_left <= '0;
      rd_pend    <= 1'b0;
      sk_valid   <= 1'b0;
      sk_data    <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= ram_re;

      // Output register refills from the skid entry first to keep order.
      if (!m_valid || pop) begin
        if (sk_valid) begin
          m_data   <= sk_data;
          m_valid  <= 1'b1;
          sk_valid <= rd_pend;
          if (rd_pend) sk_data <= ram_rdata;
        end else if (rd_pend) begin
          m_data  <= ram_rdata;
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (rd_pend) begin
        sk_data  <= ram_rdata;
        sk_valid <= 1'b1;
      end

      if (done) busy <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            state      <= READ;
            ram_addr   <= start_addr;
            issue_left <= length;
            beats_left <= length;
            busy       <= 1'b1;
          end
        end
        READ: begin
          if (ram_re) begin
            ram_addr   <= ram_addr + ADDR_WIDTH'(1);
            issue_left <= issue_left - LW'(1);
            if (issue_left == LW'(1)) state <= DRAIN;
          end
        end
        DRAIN: ;
        default: state <= IDLE;
      endcase

      // Last beat leaving the buffer closes the burst.
      if (pop && (state != IDLE)) begin
        beats_left <= beats_left - LW'(1);
        if (beats_left == LW'(1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a 1-cycle-latency RAM model
// holding mem[a] = a + 8'h10.
module tb_ram_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] start_addr;
  logic [5:0] length;
  logic       ram_re;
  logic [4:0] ram_addr;
  logic [7:0] ram_rdata = 8'h00;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;

  ram_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .ram_re     (ram_re),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_re) ram_rdata <= 8'(ram_addr) + 8'h10;

  // Running observations of the DUT ports.
  logic [7:0] beat_q[$];
  logic [4:0] addr_q[$];
  int         re_cnt     = 0;
  int         done_cnt   = 0;
  int         stall_viol = 0;
  int         outst_viol = 0;
  int         outst      = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      outst      = 0;
      prev_stall = 1'b0;
    end else begin
      if (ram_re) begin
        re_cnt++;
        addr_q.push_back(ram_addr);
      end
      if (m_valid && m_ready) beat_q.push_back(m_data);
      if (done) done_cnt++;
      if (prev_stall && (!m_valid || (m_data !== prev_data))) stall_viol++;
      outst = outst + int'(ram_re) - int'(m_valid && m_ready);
      if (outst > 2) outst_viol++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic go(input logic [4:0] sa, input logic [5:0] len);
    start      = 1'b1;
    start_addr = sa;
    length     = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit rnd);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    m_ready = 1'b1;
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    tick();
  endtask

  task automatic check_beats(input string tag, input int base, input int sa, input int len);
    int bad = 0;
    chk({tag, "_beats"}, 32'(beat_q.size() - base), 32'(len));
    for (int i = 0; i < len; i++) begin
      if ((base + i) >= beat_q.size()) bad++;
      else if (beat_q[base + i] !== 8'(((sa + i) % 32) + 16)) bad++;
    end
    chk({tag, "_order"}, 32'(bad), 32'd0);
  endtask

  // start_addr=3, length=4 with exact cycle timing; entered from IDLE.
  task automatic burst_3_4(input string tag);
    logic [7:0] exp_d[4];
    exp_d = '{8'h13, 8'h14, 8'h15, 8'h16};
    m_ready = 1'b1;
    go(5'd3, 6'd4);
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    chk({tag, "_re0"}, 32'(ram_re), 32'd1);
    chk({tag, "_addr0"}, 32'(ram_addr), 32'd3);
    chk({tag, "_mv0"}, 32'(m_valid), 32'd0);
    tick();
    chk({tag, "_addr1"}, 32'(ram_addr), 32'd4);
    chk({tag, "_mv1"}, 32'(m_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_mv_beat"}, 32'(m_valid), 32'd1);
      chk({tag, "_data_beat"}, 32'(m_data), 32'(exp_d[i]));
      chk({tag, "_done_early"}, 32'(done), 32'd0);
    end
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    chk({tag, "_mv_end"}, 32'(m_valid), 32'd0);
    tick();
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int re0;
    int dn0;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = 5'd0;
    length     = 6'd0;
    m_ready    = 1'b1;
    tick();
    tick();
    chk("rst_re", 32'(ram_re), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_mv", 32'(m_valid), 32'd0);
    chk("rst_mdata", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Start on the very first edge after reset release.
    rst_n = 1'b1;
    burst_3_4("b34");
    check_beats("b34", 0, 3, 4);

    // Address wrap.
    base = beat_q.size();
    re0  = addr_q.size();
    go(5'd30, 6'd4);
    wait_done("wrap", 1'b0);
    check_beats("wrap", base, 30, 4);
    chk("wrap_a0", 32'(addr_q[re0 + 0]), 32'd30);
    chk("wrap_a1", 32'(addr_q[re0 + 1]), 32'd31);
    chk("wrap_a2", 32'(addr_q[re0 + 2]), 32'd0);
    chk("wrap_a3", 32'(addr_q[re0 + 3]), 32'd1);
    chk("wrap_addr_hold", 32'(ram_addr), 32'd2);

    // Random backpressure.
    base = beat_q.size();
    go(5'd12, 6'd8);
    wait_done("rnd", 1'b1);
    check_beats("rnd", base, 12, 8);

    // Sink stalled from the start: only two reads may be issued.
    base    = beat_q.size();
    re0     = re_cnt;
    m_ready = 1'b0;
    go(5'd5, 6'd5);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_re_cnt", 32'(re_cnt - re0), 32'd2);
    chk("stall_mv", 32'(m_valid), 32'd1);
    chk("stall_mdata", 32'(m_data), 32'h15);
    m_ready = 1'b1;
    wait_done("stall", 1'b0);
    check_beats("stall", base, 5, 5);

    // start while busy is ignored.
    base = beat_q.size();
    dn0  = done_cnt;
    go(5'd0, 6'd6);
    tick();
    go(5'd20, 6'd3);
    wait_done("busy_start", 1'b0);
    check_beats("busy_start", base, 0, 6);
    chk("busy_start_done_cnt", 32'(done_cnt - dn0), 32'd1);
    chk("busy_start_busy", 32'(busy), 32'd0);

    // length=0 is ignored.
    re0 = re_cnt;
    dn0 = done_cnt;
    go(5'd9, 6'd0);
    for (int i = 0; i < 4; i++) begin
      chk("len0_busy", 32'(busy), 32'd0);
      tick();
    end
    chk("len0_re", 32'(re_cnt - re0), 32'd0);
    chk("len0_done", 32'(done_cnt - dn0), 32'd0);

    // Full-size burst.
    base = beat_q.size();
    dn0  = done_cnt;
    go(5'd7, 6'd32);
    wait_done("full", 1'b0);
    check_beats("full", base, 7, 32);
    chk("full_done_cnt", 32'(done_cnt - dn0), 32'd1);

    // Reset during beat 3 of 6.
    base = beat_q.size();
    dn0  = done_cnt;
    go(5'd0, 6'd6);
    for (int i = 0; i < 100; i++) begin
      if ((beat_q.size() - base) >= 3) break;
      tick();
    end
    chk("abort_reached_beat3", 32'(beat_q.size() - base), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("abort_re", 32'(ram_re), 32'd0);
    chk("abort_mv", 32'(m_valid), 32'd0);
    chk("abort_mdata", 32'(m_data), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("abort_mv_after", 32'(m_valid), 32'd0);
      tick();
    end
    chk("abort_no_beats", 32'(beat_q.size() - base), 32'd3);
    chk("abort_no_done", 32'(done_cnt - dn0), 32'd0);
    base = beat_q.size();
    burst_3_4("post");
    check_beats("post", base, 3, 4);

    chk("stall_stability", 32'(stall_viol), 32'd0);
    chk("outstanding_max2", 32'(outst_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
